// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Instruction-fetch stage of the 64-bit MIPS pipeline. Holds the PC, drives
//   the (combinational) instruction memory address and captures the returned
//   word together with its PC into the IF/ID pipeline register. Handles
//   sequential +4 fetch, taken branch/jump redirect, hazard stall and flush.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   stall          hold PC and IF/ID
//   flush          squash IF/ID contents (bubble)
//   redirect       taken branch/jump from EX
//   redirect_pc    branch/jump target (low two bits dropped)
//   instr_data     word from instruction memory at instr_addr
//   instr_addr     current PC, to instruction memory
//   ifid_instr     registered instruction
//   ifid_pc        PC of ifid_instr
//   ifid_pc_plus4  ifid_pc + 4
//   ifid_valid     1 = real instruction, 0 = bubble
//   misalign_err   one-cycle pulse after a redirect to a non word-aligned target
module pc_fetch_unit #(
  parameter int unsigned             ADDR_W   = 64,
  parameter int unsigned             INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0,
  parameter logic [INSTR_W-1:0]      NOP_WORD = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic [INSTR_W-1:0]  instr_data,
  output logic [ADDR_W-1:0]   instr_addr,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic [ADDR_W-1:0]   ifid_pc,
  output logic [ADDR_W-1:0]   ifid_pc_plus4,
  output logic                ifid_valid,
  output logic                misalign_err
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic [ADDR_W-1:0]  ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               misalign_err_q, misalign_err_d;
  logic [ADDR_W-1:0]  pc_plus4;

  // Wraps modulo 2^ADDR_W with no flag.
  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    // PC: redirect beats stall; flush alone does not affect the PC.
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    // The word fetched alongside a redirect is on the wrong path, so it is
    // bubbled exactly like a flush; the bubble keeps the old PC fields.
    if (redirect || flush) begin
      ifid_instr_d = NOP_WORD;
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      ifid_instr_d    = instr_data;
      ifid_pc_d       = pc_q;
      ifid_pc_plus4_d = pc_plus4;
      ifid_valid_d    = 1'b1;
    end
  end

  always_comb begin
    misalign_err_d = redirect && (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= NOP_WORD;
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
      misalign_err_q  <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      misalign_err_q  <= misalign_err_d;
    end
  end

  assign instr_addr    = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign misalign_err  = misalign_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Directed bench for pc_fetch_unit. The main instance uses RESET_PC=40; a
//   second instance with RESET_PC=...FFF8 covers PC wrap-around. Instruction
//   memory returns the low 32 bits of the address as the word. Observed state
//   is compared as {instr_addr, ifid_valid, ifid_instr, ifid_pc,
//   ifid_pc_plus4, misalign_err}.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect;
  logic [63:0] redirect_pc;
  logic [31:0] instr_data;
  logic [63:0] instr_addr, ifid_pc, ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid, misalign_err;

  logic        reset_w;
  logic [31:0] instr_data_w;
  logic [63:0] instr_addr_w, ifid_pc_w, ifid_pc_plus4_w;
  logic [31:0] ifid_instr_w;
  logic        ifid_valid_w, misalign_err_w;

  logic        zero_w = 1'b0;
  logic [63:0] zero_pc_w = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [225:0] obs, obs_w, exp;

  always #5 clk = ~clk;

  assign instr_data   = instr_addr[31:0];
  assign instr_data_w = instr_addr_w[31:0];
  assign obs   = {instr_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4, misalign_err};
  assign obs_w = {instr_addr_w, ifid_valid_w, ifid_instr_w, ifid_pc_w, ifid_pc_plus4_w,
                  misalign_err_w};

  pc_fetch_unit #(
    .ADDR_W  (64),
    .INSTR_W (32),
    .RESET_PC(64'd40),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_data   (instr_data),
    .instr_addr   (instr_addr),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid   (ifid_valid),
    .misalign_err (misalign_err)
  );

  pc_fetch_unit #(
    .ADDR_W  (64),
    .INSTR_W (32),
    .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8),
    .NOP_WORD(32'h0000_0000)
  ) dut_w (
    .clk          (clk),
    .reset        (reset_w),
    .stall        (zero_w),
    .flush        (zero_w),
    .redirect     (zero_w),
    .redirect_pc  (zero_pc_w),
    .instr_data   (instr_data_w),
    .instr_addr   (instr_addr_w),
    .ifid_instr   (ifid_instr_w),
    .ifid_pc      (ifid_pc_w),
    .ifid_pc_plus4(ifid_pc_plus4_w),
    .ifid_valid   (ifid_valid_w),
    .misalign_err (misalign_err_w)
  );

  // One rising edge, then settle; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
    reset_w = 1'b1;
    step();
    step();
    n_checks++;
    exp = {64'd40, 1'b0, 32'h0, 64'd0, 64'd0, 1'b0};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_sequential();
    reset = 1'b0;
    step();
    n_checks++;
    exp = {64'd44, 1'b1, 32'd40, 64'd40, 64'd44, 1'b0};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL seq_first: got %h want %h", obs, exp);
    end
    step();
    n_checks++;
    exp = {64'd48, 1'b1, 32'd44, 64'd44, 64'd48, 1'b0};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL seq_second: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      exp = {64'd48, 1'b1, 32'd44, 64'd44, 64'd48, 1'b0};
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, exp);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      exp = {64'd52 + 64'(4 * i), 1'b1, 32'd48 + 32'(4 * i), 64'd48 + 64'(4 * i),
             64'd52 + 64'(4 * i), 1'b0};
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL stall_release[%0d]: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_redirect();
    // PC is 60 here, IF/ID holds 56.
    redirect = 1'b1; redirect_pc = 64'h100;
    step();
    n_checks++;
    exp = {64'h100, 1'b0, 32'h0, 64'd56, 64'd60, 1'b0};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL redirect_bubble: got %h want %h", obs, exp);
    end
    redirect = 1'b0;
    step();
    n_checks++;
    exp = {64'h104, 1'b1, 32'h100, 64'h100, 64'h104, 1'b0};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL redirect_target: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; stall = 1'b1; flush = 1'b1; redirect_pc = 64'h203;
    step();
    n_checks++;
    exp = {64'h200, 1'b0, 32'h0, 64'h100, 64'h104, 1'b1};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL misalign_pulse: got %h want %h", obs, exp);
    end
    redirect = 1'b0; stall = 1'b0; flush = 1'b0;
    step();
    n_checks++;
    exp = {64'h204, 1'b1, 32'h200, 64'h200, 64'h204, 1'b0};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL misalign_clear: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_flush_and_reset();
    redirect = 1'b1; redirect_pc = 64'd80;
    step();
    n_checks++;
    exp = {64'd80, 1'b0, 32'h0, 64'h200, 64'h204, 1'b0};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL flush_setup: got %h want %h", obs, exp);
    end
    redirect = 1'b0; flush = 1'b1;
    step();
    n_checks++;
    exp = {64'd84, 1'b0, 32'h0, 64'h200, 64'h204, 1'b0};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL flush_only: got %h want %h", obs, exp);
    end
    flush = 1'b0;
    step();
    n_checks++;
    exp = {64'd88, 1'b1, 32'd84, 64'd84, 64'd88, 1'b0};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL flush_resume: got %h want %h", obs, exp);
    end
    stall = 1'b1;
    step();
    n_checks++;
    exp = {64'd88, 1'b1, 32'd84, 64'd84, 64'd88, 1'b0};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL stall_before_reset: got %h want %h", obs, exp);
    end
    // Reset must win over stall and a misaligned redirect.
    reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h3;
    step();
    n_checks++;
    exp = {64'd40, 1'b0, 32'h0, 64'd0, 64'd0, 1'b0};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_midstream: got %h want %h", obs, exp);
    end
    reset = 1'b0; redirect = 1'b0; stall = 1'b0; redirect_pc = '0;
    step();
    n_checks++;
    exp = {64'd44, 1'b1, 32'd40, 64'd40, 64'd44, 1'b0};
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL after_reset_fetch: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_wrap();
    reset_w = 1'b0;
    n_checks++;
    exp = {64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 32'h0, 64'd0, 64'd0, 1'b0};
    if (obs_w !== exp) begin
      n_fail++;
      $display("FAIL wrap_reset: got %h want %h", obs_w, exp);
    end
    step();
    n_checks++;
    exp = {64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8,
           64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    if (obs_w !== exp) begin
      n_fail++;
      $display("FAIL wrap_fffc: got %h want %h", obs_w, exp);
    end
    step();
    n_checks++;
    exp = {64'd0, 1'b1, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0};
    if (obs_w !== exp) begin
      n_fail++;
      $display("FAIL wrap_zero: got %h want %h", obs_w, exp);
    end
    step();
    n_checks++;
    exp = {64'd4, 1'b1, 32'h0, 64'd0, 64'd4, 1'b0};
    if (obs_w !== exp) begin
      n_fail++;
      $display("FAIL wrap_after: got %h want %h", obs_w, exp);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misalign();
    test_flush_and_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
